// File: rtl/alu_md_pkg.sv
// Shared definitions for the execute-stage ALU and the multiply/divide unit:
// operation encodings, MD state names and the divide-by-zero-safe divider.
package alu_md_pkg;

  // ALU operation select (alu_ctrl)
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_SLT  = 4'd10;

  // Multiply/divide operation select (md_op); 6 and 7 are reserved
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // MD unit state, derived from its cycle counter (RUN whenever count != 0)
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  // Widest datapath the shared divider supports; callers extend operands
  // to this width (sign- or zero-extension) and keep the low bits.
  localparam int MD_MAX_W = 64;

  typedef struct packed {
    logic [MD_MAX_W-1:0] quo;
    logic [MD_MAX_W-1:0] rem;
    logic                ok;   // 0 when the divisor was zero
  } div_res_t;

  // Divide that never evaluates x/0. Signed division truncates toward zero
  // with the remainder taking the dividend's sign. A divisor of -1 is done
  // as a wrapping negate so that min/-1 yields min with remainder 0 even at
  // the full MD_MAX_W width.
  function automatic div_res_t div_safe(input logic [MD_MAX_W-1:0] num,
                                        input logic [MD_MAX_W-1:0] den,
                                        input logic                is_signed);
    div_res_t res;
    res = '0;
    if (den == '0) begin
      res.ok = 1'b0;
    end else if (is_signed && (&den)) begin
      res.quo = -num;
      res.rem = '0;
      res.ok  = 1'b1;
    end else if (is_signed) begin
      res.quo = MD_MAX_W'($signed(num) / $signed(den));
      res.rem = MD_MAX_W'($signed(num) % $signed(den));
      res.ok  = 1'b1;
    end else begin
      res.quo = num / den;
      res.rem = num % den;
      res.ok  = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_md_md_unit.sv
// Multiply/divide unit: owns HI/LO, computes the full result at issue time
// into pending registers and exposes it only after a fixed busy window, so
// the hazard unit sees the same latency as an iterative implementation.
// Supports WIDTH up to MD_MAX_W.
module md_unit
  import alu_md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  input  logic             md_cancel,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_pend_hi;
  logic [WIDTH-1:0] r_pend_lo;
  logic             r_pend_wr;   // commit writes HI/LO (cleared for x/0)

  md_state_t          w_state;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic               w_div_signed;
  logic [MD_MAX_W-1:0] w_num;
  logic [MD_MAX_W-1:0] w_den;
  logic [2*WIDTH:0]    w_div;     // {ok, remainder, quotient}

  // Narrow the shared wide divider result to this datapath width.
  function automatic logic [2*WIDTH:0] div_narrow(input logic [MD_MAX_W-1:0] n,
                                                  input logic [MD_MAX_W-1:0] d,
                                                  input logic                s);
    div_res_t r;
    r = div_safe(n, d, s);
    return {r.ok, r.rem[WIDTH-1:0], r.quo[WIDTH-1:0]};
  endfunction

  assign w_state = (r_count != '0) ? MD_RUN : MD_IDLE;

  // Full-width products; the signed one uses sign-extended operands so the
  // truncated 2*WIDTH product is exact.
  assign w_prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign w_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign w_div_signed = (md_op == MD_DIV);
  assign w_num = w_div_signed ? MD_MAX_W'($signed(a)) : MD_MAX_W'(a);
  assign w_den = w_div_signed ? MD_MAX_W'($signed(b)) : MD_MAX_W'(b);
  assign w_div = div_narrow(w_num, w_den, w_div_signed);

  // Issue, count down, commit or cancel; all MD state lives in this block.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in the block.
  // NOTE: pending registers are plain flops (not a memory array), so they are
  // reset together with HI/LO to keep the unit fully defined after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else if (w_state == MD_RUN) begin
      if (md_cancel) begin
        // Exception flush: drop the in-flight result, keep HI/LO.
        r_count   <= '0;
        r_busy    <= 1'b0;
        r_pend_hi <= '0;
        r_pend_lo <= '0;
        r_pend_wr <= 1'b0;
      end else begin
        // New starts are ignored here; the hazard unit stalls instead.
        r_count <= r_count - CNT_ONE;
        r_busy  <= (r_count != CNT_ONE);
        if ((r_count == CNT_ONE) && r_pend_wr) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end
    end else if (md_start && !md_cancel) begin
      case (md_op)
        MD_MULT: begin
          r_pend_hi <= w_prod_s[2*WIDTH-1:WIDTH];
          r_pend_lo <= w_prod_s[WIDTH-1:0];
          r_pend_wr <= 1'b1;
          r_count   <= MUL_LOAD;
          r_busy    <= 1'b1;
        end
        MD_MULTU: begin
          r_pend_hi <= w_prod_u[2*WIDTH-1:WIDTH];
          r_pend_lo <= w_prod_u[WIDTH-1:0];
          r_pend_wr <= 1'b1;
          r_count   <= MUL_LOAD;
          r_busy    <= 1'b1;
        end
        MD_DIV, MD_DIVU: begin
          r_pend_hi <= w_div[2*WIDTH-1:WIDTH];
          r_pend_lo <= w_div[WIDTH-1:0];
          r_pend_wr <= w_div[2*WIDTH];
          r_count   <= DIV_LOAD;
          r_busy    <= 1'b1;
        end
        MD_MTHI: r_hi <= a;
        MD_MTLO: r_lo <= a;
        default: ;
      endcase
    end
  end

  assign md_busy = r_busy;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule

// File: rtl/alu_md.sv
// Execute-stage arithmetic: combinational ALU with signed-overflow flag for
// add/sub, plus the multi-cycle multiply/divide unit that owns HI/LO.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  input  logic             md_cancel,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SA_W = $clog2(WIDTH);

  logic [SA_W-1:0]  w_sa;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_ltu;
  logic             w_lts;

  // Only the low log2(WIDTH) bits of a select the shift distance.
  assign w_sa   = a[SA_W-1:0];
  assign w_sum  = a + b;
  assign w_diff = a - b;

  // Overflow: like-signed operands (add) or unlike-signed operands (sub)
  // producing a result whose sign differs from a.
  assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1]  != a[WIDTH-1]);
  assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

  assign w_ltu = (a < b);
  assign w_lts = ($signed(a) < $signed(b));

  // ALU result select; overflow is only meaningful for add/sub.
  // NOTE: both outputs get a default before the case so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_ctrl)
      ALU_ADD: begin
        result   = w_sum;
        overflow = w_add_ovf;
      end
      ALU_SUB: begin
        result   = w_diff;
        overflow = w_sub_ovf;
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_NOR:  result = ~(a | b);
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = b << w_sa;
      ALU_SRL:  result = b >> w_sa;
      ALU_SRA:  result = $signed(b) >>> w_sa;
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, w_ltu};
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, w_lts};
      default:  result = '0;
    endcase
  end

  md_unit #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_unit (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .md_op     (md_op),
    .md_start  (md_start),
    .md_cancel (md_cancel),
    .md_busy   (md_busy),
    .hi        (hi),
    .lo        (lo)
  );

endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: ALU vectors, multiply/divide latency and
// results, divide by zero, cancel, ignored starts and asynchronous reset.
module tb_alu_md;
  import alu_md_pkg::*;

  localparam int W     = 32;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic         clk;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] result;
  logic         overflow;
  logic [2:0]   md_op;
  logic         md_start;
  logic         md_cancel;
  logic         md_busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  alu_md #(
    .WIDTH      (W),
    .MUL_CYCLES (MUL_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .alu_ctrl  (alu_ctrl),
    .result    (result),
    .overflow  (overflow),
    .md_op     (md_op),
    .md_start  (md_start),
    .md_cancel (md_cancel),
    .md_busy   (md_busy),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one md_start strobe during a cycle; returns at the falling edge of
  // the following cycle (cycle 1 relative to the issue cycle).
  task automatic issue(input logic [2:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic cancel);
    @(negedge clk);
    md_op     = op;
    a         = x;
    b         = y;
    md_start  = 1'b1;
    md_cancel = cancel;
    @(negedge clk);
    md_start  = 1'b0;
    md_cancel = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", md_busy); end
    checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", md_busy); end
  endtask

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] res;
    logic         ovf;
  } alu_vec_t;

  task automatic test_alu();
    alu_vec_t v[16];
    v[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    v[1]  = '{ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    v[2]  = '{ALU_SRA,  32'h00000024, 32'h80000000, 32'hF8000000, 1'b0};
    v[3]  = '{ALU_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    v[4]  = '{ALU_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    v[5]  = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    v[6]  = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    v[7]  = '{ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    v[8]  = '{ALU_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0};
    v[9]  = '{ALU_NOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0};
    v[10] = '{ALU_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0};
    v[11] = '{ALU_SLL,  32'h00000021, 32'h80000001, 32'h00000002, 1'b0};
    v[12] = '{ALU_SRL,  32'h00000004, 32'h80000000, 32'h08000000, 1'b0};
    v[13] = '{4'd11,    32'h00000005, 32'h00000003, 32'h00000000, 1'b0};
    v[14] = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    v[15] = '{ALU_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      alu_ctrl = v[i].ctrl;
      a        = v[i].va;
      b        = v[i].vb;
      #1;
      checks++;
      if (result !== v[i].res) begin
        errors++;
        $display("FAIL alu_result[%0d] ctrl=%0d got %h want %h", i, v[i].ctrl, result, v[i].res);
      end
      checks++;
      if (overflow !== v[i].ovf) begin
        errors++;
        $display("FAIL alu_overflow[%0d] ctrl=%0d got %b want %b", i, v[i].ctrl, overflow, v[i].ovf);
      end
    end
    alu_ctrl = ALU_ADD;
  endtask

  // One full MD operation: busy for exactly n cycles, HI/LO held until the
  // commit, new values visible in the first non-busy cycle.
  task automatic test_md_op(input string name, input logic [2:0] op,
                            input logic [W-1:0] x, input logic [W-1:0] y, input int n,
                            input logic [W-1:0] old_hi, input logic [W-1:0] old_lo,
                            input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    issue(op, x, y, 1'b0);
    for (int i = 1; i <= n; i++) begin
      checks++;
      if (md_busy !== 1'b1) begin errors++; $display("FAIL %s busy_cycle%0d got %b want 1", name, i, md_busy); end
      if (i == n) begin
        checks++;
        if (hi !== old_hi || lo !== old_lo) begin
          errors++;
          $display("FAIL %s early_commit got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, old_hi, old_lo);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL %s busy_end got %b want 0", name, md_busy); end
    checks++;
    if (hi !== exp_hi) begin errors++; $display("FAIL %s hi got %h want %h", name, hi, exp_hi); end
    checks++;
    if (lo !== exp_lo) begin errors++; $display("FAIL %s lo got %h want %h", name, lo, exp_lo); end
  endtask

  task automatic test_mult();
    test_md_op("mult",  MD_MULT,  32'hFFFFFFFD, 32'd5, MUL_N,
               32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1);
    test_md_op("multu", MD_MULTU, 32'hFFFFFFFD, 32'd5, MUL_N,
               32'hFFFFFFFF, 32'hFFFFFFF1, 32'h00000004, 32'hFFFFFFF1);
  endtask

  task automatic test_div();
    test_md_op("div_neg",  MD_DIV,  32'hFFFFFFF9, 32'd2, DIV_N,
               32'h00000004, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    test_md_op("divu",     MD_DIVU, 32'd7, 32'd2, DIV_N,
               32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd3);
    test_md_op("div_negb", MD_DIV,  32'd7, 32'hFFFFFFFE, DIV_N,
               32'd1, 32'd3, 32'd1, 32'hFFFFFFFD);
    test_md_op("div_min",  MD_DIV,  32'h80000000, 32'hFFFFFFFF, DIV_N,
               32'd1, 32'hFFFFFFFD, 32'd0, 32'h80000000);
  endtask

  task automatic test_div_zero();
    issue(MD_MTHI, 32'd5, 32'd0, 1'b0);
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b want 0", md_busy); end
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL mthi_hi got %h want 5", hi); end
    issue(MD_MTLO, 32'd9, 32'd0, 1'b0);
    checks++; if (lo !== 32'd9) begin errors++; $display("FAIL mtlo_lo got %h want 9", lo); end
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL mtlo_hi got %h want 5", hi); end
    test_md_op("divu_zero", MD_DIVU, 32'd123, 32'd0, DIV_N,
               32'd5, 32'd9, 32'd5, 32'd9);
    test_md_op("div_zero",  MD_DIV,  32'hFFFFFFF0, 32'd0, DIV_N,
               32'd5, 32'd9, 32'd5, 32'd9);
  endtask

  task automatic test_cancel();
    issue(MD_MULT, 32'd3, 32'd4, 1'b0);
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL cancel_busy1 got %b want 1", md_busy); end
    @(negedge clk);
    md_cancel = 1'b1;
    @(negedge clk);
    md_cancel = 1'b0;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL cancel_busy_after got %b want 0", md_busy); end
    checks++;
    if (hi !== 32'd5 || lo !== 32'd9) begin
      errors++; $display("FAIL cancel_hold got hi=%h lo=%h want hi=5 lo=9", hi, lo);
    end
    repeat (MUL_N) @(negedge clk);
    checks++;
    if (md_busy !== 1'b0 || hi !== 32'd5 || lo !== 32'd9) begin
      errors++; $display("FAIL cancel_late got busy=%b hi=%h lo=%h want busy=0 hi=5 lo=9", md_busy, hi, lo);
    end
    // Cancel together with start while idle: nothing starts, nothing written.
    issue(MD_MULT, 32'd3, 32'd4, 1'b1);
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL idle_cancel_busy got %b want 0", md_busy); end
    issue(MD_MTHI, 32'd77, 32'd0, 1'b1);
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL idle_cancel_mthi got %h want 5", hi); end
  endtask

  task automatic test_back_to_back();
    issue(MD_MULT, 32'd3, 32'd4, 1'b0);
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy1 got %b want 1", md_busy); end
    @(negedge clk);
    md_op = MD_MULTU; a = 32'd100; b = 32'd100; md_start = 1'b1;
    @(negedge clk);
    md_op = MD_MTHI; a = 32'hDEADBEEF;
    @(negedge clk);
    md_start = 1'b0;
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy4 got %b want 1", md_busy); end
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b1 || hi !== 32'd5 || lo !== 32'd9) begin
      errors++; $display("FAIL b2b_cycle5 got busy=%b hi=%h lo=%h want busy=1 hi=5 lo=9", md_busy, hi, lo);
    end
    @(negedge clk);
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy6 got %b want 0", md_busy); end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      errors++; $display("FAIL b2b_commit got hi=%h lo=%h want hi=0 lo=c", hi, lo);
    end
    repeat (DIV_N) @(negedge clk);
    checks++;
    if (md_busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd12) begin
      errors++; $display("FAIL b2b_single_commit got busy=%b hi=%h lo=%h want busy=0 hi=0 lo=c", md_busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy4 got %b want 1", md_busy); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", md_busy); end
    checks++; if (hi !== '0) begin errors++; $display("FAIL rmid_hi got %h want 0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("FAIL rmid_lo got %h want 0", lo); end
    @(negedge clk);
    reset = 1'b0;
    issue(MD_MTLO, 32'h000000A5, 32'd0, 1'b0);
    checks++; if (lo !== 32'h000000A5) begin errors++; $display("FAIL rmid_mtlo got %h want a5", lo); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rmid_mtlo_busy got %b want 0", md_busy); end
    repeat (DIV_N) @(negedge clk);
    checks++;
    if (md_busy !== 1'b0 || hi !== 32'd0 || lo !== 32'h000000A5) begin
      errors++; $display("FAIL rmid_no_commit got busy=%b hi=%h lo=%h want busy=0 hi=0 lo=a5", md_busy, hi, lo);
    end
  endtask

  initial begin
    reset     = 1'b1;
    a         = '0;
    b         = '0;
    alu_ctrl  = ALU_ADD;
    md_op     = MD_MULT;
    md_start  = 1'b0;
    md_cancel = 1'b0;
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_div_zero();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
